wbu: RTL and testbench
======================

// Module: wbu
// PURPOSE
//  Write-back unit. Sits between the LSU and the register file in the multi-cycle core.
//  Takes one retired instruction from the LSU over a valid/ready handshake.
//  Selects the write-back value (ALU, formatted load data, PC+4 or CSR) and drives a
//  one-cycle GPR write into the register file.
//  Then hands dnpc to the IFU over a valid/ready handshake, which closes the instruction loop.
// PARAMETERS
//  XLEN  32  data/address width; must equal `RegBus width
// PORTS
//  clk              in   1     system clock; all state updates on posedge
//  rst              in   1     synchronous reset, active-high (`RST_VAL)
//  i_lsu_valid      in   1     LSU presents an instruction
//  o_lsu_ready      out  1     WBU can accept (IDLE only)
//  i_lsu_pc         in   XLEN  pc of instruction
//  i_lsu_dnpc       in   XLEN  dynamic next pc
//  i_lsu_alu_res    in   XLEN  EXU result
//  i_lsu_csr_rdata  in   XLEN  old CSR value (csrr*)
//  i_lsu_mem_rdata  in   XLEN  raw aligned memory word
//  i_lsu_addr_lo    in   2     load address bits [1:0]
//  i_lsu_funct3     in   3     load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//  i_lsu_res_sel    in   2     00 ALU, 01 LOAD, 10 PC+4, 11 CSR
//  i_lsu_gpr_wen    in   1     instruction writes rd
//  i_lsu_rd_id      in   5     destination register
//  o_rf_gpr_wen     out  1     register file write enable
//  o_rf_rd_id       out  5     register file write index
//  o_rf_rd          out  XLEN  register file write data
//  o_ifu_valid      out  1     dnpc is valid for IFU
//  i_ifu_ready      in   1     IFU accepts dnpc
//  o_ifu_dnpc       out  XLEN  next pc to fetch
// BEHAVIOUR
//  FSM states IDLE -> WRITE -> COMMIT -> IDLE. All outputs are registered or decoded from state.
//  IDLE
//   - o_lsu_ready=1.
//   - On i_lsu_valid: latch all i_lsu_* fields and compute the wb value; go to WRITE.
//  WRITE (exactly 1 cycle)
//   - o_rf_gpr_wen = latched gpr_wen && rd_id!=0.
//   - o_rf_rd_id and o_rf_rd are driven from the latch, so the RF updates at the end of this cycle.
//   - Go to COMMIT.
//  COMMIT
//   - o_ifu_valid=1 and o_ifu_dnpc=latched dnpc; both hold stable until i_ifu_ready.
//   - On i_ifu_ready: go to IDLE.
//   - If i_ifu_ready arrives the same cycle valid first rises, leave at that edge.
//  Latency: accept at edge N; RF write during cycle N+1; o_ifu_valid first high in cycle N+2.
//  Throughput: at most 1 instruction per 3 cycles. No new LSU accept before COMMIT completes.
//  o_lsu_ready=0 in WRITE and COMMIT. An i_lsu_valid held high there is accepted only on return to IDLE.
//  o_rf_gpr_wen is low outside WRITE.
//  rd_id==0 never asserts o_rf_gpr_wen; the instruction still commits.
//  Result select
//   - PC+4 = pc + 4, wrapping mod 2^XLEN (0xFFFFFFFC -> 0x0).
//  Load format (LOAD sel only)
//   - Byte lane = addr_lo.
//   - Half lane = addr_lo[1]; addr_lo[0] is ignored.
//   - LW ignores addr_lo.
//   - LB/LH sign-extend; LBU/LHU zero-extend.
//   - Other funct3 values yield 0.
//  Reset (any state, including mid-operation)
//   - State goes to IDLE and the latched instruction is discarded.
//   - After reset: o_lsu_ready=1, o_rf_gpr_wen=0, o_rf_rd_id=0, o_rf_rd=0, o_ifu_valid=0, o_ifu_dnpc=0.
//   - No RF write or IFU commit is issued for the discarded instruction.
// STRUCTURE
//  Shared defines file additions:
//   - WBU state encodings (2-bit).
//   - Result-select codes.
//   - Load funct3 codes.
//   - Reuse `RegBus, `Reg_x0 and `RST_VAL.
//  Sub-module wbu_load_fmt: combinational (rdata, addr_lo, funct3) -> XLEN result.
//  Top module holds the FSM, the latch and the output muxing.
// TESTING
//  1. Reset test
//     - Stimulus: assert rst mid-COMMIT.
//     - Required: next cycle in IDLE, o_ifu_valid=0, all outputs 0 except o_lsu_ready=1.
//  2. ALU write-back
//     - Stimulus: sel=00, alu_res=0x12345678, rd=5, wen=1, dnpc=0x80000004.
//     - Required: wen high for exactly 1 cycle with rd_id=5, rd=0x12345678.
//     - Required: then o_ifu_dnpc=0x80000004 held valid.
//  3. Load formatting on rdata=0x80FF7F01
//     - LB  lo=2 -> 0xFFFFFFFF
//     - LBU lo=3 -> 0x00000080
//     - LH  lo=0 -> 0x00007F01
//     - LHU lo=2 -> 0x000080FF
//     - LH  lo=3 -> 0xFFFF80FF
//     - LW -> 0x80FF7F01
//  4. PC+4 and CSR selects
//     - PC+4, pc=0xFFFFFFFC -> rd=0x00000000.
//     - CSR, csr_rdata=0x00001800 -> rd=0x00001800.
//  5. x0 / no-write
//     - Stimulus: rd=0 with wen=1; separately wen=0 with rd=7.
//     - Required: o_rf_gpr_wen never high; o_ifu_valid still asserted.
//  6. Backpressure
//     - Stimulus: hold i_ifu_ready=0 for 5 cycles while i_lsu_valid=1.
//     - Required: dnpc stable, o_lsu_ready=0 throughout.
//     - Required: second instruction accepted the cycle after the ready handshake.

Source files
------------

// File: rtl/wbu_pkg.sv
// Shared encodings for the write-back unit: FSM states, result selects, load types.
package wbu_pkg;

   localparam int XLEN = 32;
   localparam logic [4:0] REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_WRITE  = 2'b01,
      ST_COMMIT = 2'b10
   } wbu_state_e;

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;
   localparam logic [1:0] SEL_CSR  = 2'b11;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wbu_load_fmt.sv
// Extracts and extends the addressed byte/half/word from an aligned memory word.
module wbu_load_fmt
   import wbu_pkg::*;
#(
   parameter int W = XLEN
) (
   input  logic [W-1:0] rdata,
   input  logic [1:0]   addr_lo,
   input  logic [2:0]   funct3,
   output logic [W-1:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = rdata[{addr_lo, 3'b000} +: 8];
      // halfword lane comes from addr_lo[1] only; misaligned bit 0 is dropped
      half_v = addr_lo[1] ? rdata[16 +: 16] : rdata[0 +: 16];
      case (funct3)
         F3_LB:   result = {{(W-8){byte_v[7]}}, byte_v};
         F3_LH:   result = {{(W-16){half_v[15]}}, half_v};
         F3_LW:   result = rdata;
         F3_LBU:  result = {{(W-8){1'b0}}, byte_v};
         F3_LHU:  result = {{(W-16){1'b0}}, half_v};
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/wbu.sv
// Write-back unit: accepts one retired instruction, writes the GPR for one cycle,
// then offers dnpc to the IFU. IDLE -> WRITE -> COMMIT -> IDLE.
module wbu
   import wbu_pkg::*;
#(
   parameter int XLEN_P = XLEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_lsu_valid,
   output logic              o_lsu_ready,
   input  logic [XLEN_P-1:0] i_lsu_pc,
   input  logic [XLEN_P-1:0] i_lsu_dnpc,
   input  logic [XLEN_P-1:0] i_lsu_alu_res,
   input  logic [XLEN_P-1:0] i_lsu_csr_rdata,
   input  logic [XLEN_P-1:0] i_lsu_mem_rdata,
   input  logic [1:0]        i_lsu_addr_lo,
   input  logic [2:0]        i_lsu_funct3,
   input  logic [1:0]        i_lsu_res_sel,
   input  logic              i_lsu_gpr_wen,
   input  logic [4:0]        i_lsu_rd_id,
   output logic              o_rf_gpr_wen,
   output logic [4:0]        o_rf_rd_id,
   output logic [XLEN_P-1:0] o_rf_rd,
   output logic              o_ifu_valid,
   input  logic              i_ifu_ready,
   output logic [XLEN_P-1:0] o_ifu_dnpc
);

   wbu_state_e        state_q, state_d;
   logic              wen_q, wen_d;
   logic [4:0]        rd_id_q, rd_id_d;
   logic [XLEN_P-1:0] wb_q, wb_d;
   logic [XLEN_P-1:0] dnpc_q, dnpc_d;
   logic [XLEN_P-1:0] load_val;
   logic [XLEN_P-1:0] wb_val;

   wbu_load_fmt #(.W(XLEN_P)) u_load_fmt (
      .rdata   (i_lsu_mem_rdata),
      .addr_lo (i_lsu_addr_lo),
      .funct3  (i_lsu_funct3),
      .result  (load_val)
   );

   always_comb begin
      case (i_lsu_res_sel)
         SEL_ALU:  wb_val = i_lsu_alu_res;
         SEL_LOAD: wb_val = load_val;
         SEL_PC4:  wb_val = i_lsu_pc + XLEN_P'(4);
         default:  wb_val = i_lsu_csr_rdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      wen_d   = wen_q;
      rd_id_d = rd_id_q;
      wb_d    = wb_q;
      dnpc_d  = dnpc_q;
      case (state_q)
         ST_IDLE: begin
            if (i_lsu_valid) begin
               state_d = ST_WRITE;
               // x0 suppression is folded in at accept so WRITE is a pure decode
               wen_d   = i_lsu_gpr_wen && (i_lsu_rd_id != REG_X0);
               rd_id_d = i_lsu_rd_id;
               wb_d    = wb_val;
               dnpc_d  = i_lsu_dnpc;
            end
         end
         ST_WRITE:  state_d = ST_COMMIT;
         ST_COMMIT: if (i_ifu_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wen_q   <= 1'b0;
         rd_id_q <= '0;
         wb_q    <= '0;
         dnpc_q  <= '0;
      end else begin
         state_q <= state_d;
         wen_q   <= wen_d;
         rd_id_q <= rd_id_d;
         wb_q    <= wb_d;
         dnpc_q  <= dnpc_d;
      end
   end

   assign o_lsu_ready  = (state_q == ST_IDLE);
   assign o_rf_gpr_wen = (state_q == ST_WRITE) && wen_q;
   assign o_rf_rd_id   = rd_id_q;
   assign o_rf_rd      = wb_q;
   assign o_ifu_valid  = (state_q == ST_COMMIT);
   assign o_ifu_dnpc   = dnpc_q;

endmodule

// File: tb/tb_wbu.sv
// Directed bench for the write-back unit with hand-computed expectations.
module tb_wbu;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_lsu_valid;
   logic        o_lsu_ready;
   logic [31:0] i_lsu_pc, i_lsu_dnpc, i_lsu_alu_res, i_lsu_csr_rdata, i_lsu_mem_rdata;
   logic [1:0]  i_lsu_addr_lo;
   logic [2:0]  i_lsu_funct3;
   logic [1:0]  i_lsu_res_sel;
   logic        i_lsu_gpr_wen;
   logic [4:0]  i_lsu_rd_id;
   logic        o_rf_gpr_wen;
   logic [4:0]  o_rf_rd_id;
   logic [31:0] o_rf_rd;
   logic        o_ifu_valid;
   logic        i_ifu_ready;
   logic [31:0] o_ifu_dnpc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wbu dut (
      .clk(clk), .rst(rst),
      .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
      .i_lsu_pc(i_lsu_pc), .i_lsu_dnpc(i_lsu_dnpc),
      .i_lsu_alu_res(i_lsu_alu_res), .i_lsu_csr_rdata(i_lsu_csr_rdata),
      .i_lsu_mem_rdata(i_lsu_mem_rdata), .i_lsu_addr_lo(i_lsu_addr_lo),
      .i_lsu_funct3(i_lsu_funct3), .i_lsu_res_sel(i_lsu_res_sel),
      .i_lsu_gpr_wen(i_lsu_gpr_wen), .i_lsu_rd_id(i_lsu_rd_id),
      .o_rf_gpr_wen(o_rf_gpr_wen), .o_rf_rd_id(o_rf_rd_id), .o_rf_rd(o_rf_rd),
      .o_ifu_valid(o_ifu_valid), .i_ifu_ready(i_ifu_ready), .o_ifu_dnpc(o_ifu_dnpc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] csr,
                        input logic [31:0] mem, input logic [1:0] lo, input logic [2:0] f3,
                        input logic [31:0] pc, input logic [31:0] dnpc,
                        input logic wen, input logic [4:0] rd);
      i_lsu_res_sel   = sel;
      i_lsu_alu_res   = alu;
      i_lsu_csr_rdata = csr;
      i_lsu_mem_rdata = mem;
      i_lsu_addr_lo   = lo;
      i_lsu_funct3    = f3;
      i_lsu_pc        = pc;
      i_lsu_dnpc      = dnpc;
      i_lsu_gpr_wen   = wen;
      i_lsu_rd_id     = rd;
   endtask

   // Full transaction with IFU ready on first COMMIT cycle; checks the WRITE and COMMIT cycles.
   task automatic run(input string tag, input logic [1:0] sel, input logic [31:0] alu,
                      input logic [31:0] csr, input logic [31:0] mem, input logic [1:0] lo,
                      input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] dnpc,
                      input logic wen, input logic [4:0] rd,
                      input logic exp_wen, input logic [31:0] exp_rd);
      chk({tag, ".ready_idle"}, 32'(o_lsu_ready), 32'd1);
      drive(sel, alu, csr, mem, lo, f3, pc, dnpc, wen, rd);
      i_lsu_valid = 1'b1;
      tick();
      i_lsu_valid = 1'b0;
      chk({tag, ".wen"},     32'(o_rf_gpr_wen), 32'(exp_wen));
      chk({tag, ".rd"},      o_rf_rd, exp_rd);
      chk({tag, ".rd_id"},   32'(o_rf_rd_id), 32'(rd));
      chk({tag, ".wr_vld"},  32'(o_ifu_valid), 32'd0);
      tick();
      chk({tag, ".cm_wen"},  32'(o_rf_gpr_wen), 32'd0);
      chk({tag, ".cm_vld"},  32'(o_ifu_valid), 32'd1);
      chk({tag, ".dnpc"},    o_ifu_dnpc, dnpc);
      i_ifu_ready = 1'b1;
      tick();
      i_ifu_ready = 1'b0;
      chk({tag, ".back_idle"}, 32'(o_lsu_ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      i_lsu_valid = 1'b0;
      i_ifu_ready = 1'b0;
      drive(2'b00, 0, 0, 0, 2'd0, 3'd0, 0, 0, 1'b0, 5'd0);
      tick();
      tick();
      rst = 1'b0;
      chk("rst0.ready", 32'(o_lsu_ready), 32'd1);
      chk("rst0.wen",   32'(o_rf_gpr_wen), 32'd0);
      chk("rst0.vld",   32'(o_ifu_valid), 32'd0);
      chk("rst0.dnpc",  o_ifu_dnpc, 32'd0);

      // ALU write-back
      run("alu", 2'b00, 32'h12345678, 0, 0, 2'd0, 3'd0, 32'h80000000, 32'h80000004,
          1'b1, 5'd5, 1'b1, 32'h12345678);

      // Load formatting on 0x80FF7F01
      run("lb2",  2'b01, 0, 0, 32'h80FF7F01, 2'd2, 3'b000, 0, 32'h100, 1'b1, 5'd1, 1'b1, 32'hFFFFFFFF);
      run("lbu3", 2'b01, 0, 0, 32'h80FF7F01, 2'd3, 3'b100, 0, 32'h104, 1'b1, 5'd2, 1'b1, 32'h00000080);
      run("lh0",  2'b01, 0, 0, 32'h80FF7F01, 2'd0, 3'b001, 0, 32'h108, 1'b1, 5'd3, 1'b1, 32'h00007F01);
      run("lhu2", 2'b01, 0, 0, 32'h80FF7F01, 2'd2, 3'b101, 0, 32'h10C, 1'b1, 5'd4, 1'b1, 32'h000080FF);
      run("lh3",  2'b01, 0, 0, 32'h80FF7F01, 2'd3, 3'b001, 0, 32'h110, 1'b1, 5'd6, 1'b1, 32'hFFFF80FF);
      run("lw",   2'b01, 0, 0, 32'h80FF7F01, 2'd1, 3'b010, 0, 32'h114, 1'b1, 5'd8, 1'b1, 32'h80FF7F01);
      run("lbad", 2'b01, 0, 0, 32'h80FF7F01, 2'd0, 3'b011, 0, 32'h118, 1'b1, 5'd9, 1'b1, 32'h00000000);

      // PC+4 wrap and CSR
      run("pc4", 2'b10, 32'hDEADBEEF, 0, 0, 2'd0, 3'd0, 32'hFFFFFFFC, 32'h200, 1'b1, 5'd1, 1'b1, 32'h00000000);
      run("csr", 2'b11, 32'hDEADBEEF, 32'h00001800, 0, 2'd0, 3'd0, 0, 32'h204, 1'b1, 5'd10, 1'b1, 32'h00001800);

      // x0 and no-write still commit
      run("x0",   2'b00, 32'hAAAA5555, 0, 0, 2'd0, 3'd0, 0, 32'h300, 1'b1, 5'd0, 1'b0, 32'hAAAA5555);
      run("nwen", 2'b00, 32'h5555AAAA, 0, 0, 2'd0, 3'd0, 0, 32'h304, 1'b0, 5'd7, 1'b0, 32'h5555AAAA);

      // Backpressure: IFU stalls 5 COMMIT cycles while the next LSU instruction waits
      drive(2'b00, 32'h11111111, 0, 0, 2'd0, 3'd0, 0, 32'h400, 1'b1, 5'd11);
      i_lsu_valid = 1'b1;
      tick();
      drive(2'b00, 32'h22222222, 0, 0, 2'd0, 3'd0, 0, 32'h500, 1'b1, 5'd12);
      chk("bp.wr_ready", 32'(o_lsu_ready), 32'd0);
      chk("bp.wr_rd",    o_rf_rd, 32'h11111111);
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp.vld",   32'(o_ifu_valid), 32'd1);
         chk("bp.dnpc",  o_ifu_dnpc, 32'h400);
         chk("bp.ready", 32'(o_lsu_ready), 32'd0);
         chk("bp.wen",   32'(o_rf_gpr_wen), 32'd0);
         tick();
      end
      i_ifu_ready = 1'b1;
      chk("bp.hs_vld", 32'(o_ifu_valid), 32'd1);
      tick();
      i_ifu_ready = 1'b0;
      chk("bp.idle_ready", 32'(o_lsu_ready), 32'd1);
      chk("bp.idle_vld",   32'(o_ifu_valid), 32'd0);
      tick();
      i_lsu_valid = 1'b0;
      chk("bp.b_wen",   32'(o_rf_gpr_wen), 32'd1);
      chk("bp.b_rd",    o_rf_rd, 32'h22222222);
      chk("bp.b_rd_id", 32'(o_rf_rd_id), 32'd12);
      tick();
      chk("bp.b_dnpc",  o_ifu_dnpc, 32'h500);
      i_ifu_ready = 1'b1;
      tick();
      i_ifu_ready = 1'b0;

      // Reset while in COMMIT discards the instruction
      drive(2'b00, 32'hCAFEF00D, 0, 0, 2'd0, 3'd0, 0, 32'h600, 1'b1, 5'd13);
      i_lsu_valid = 1'b1;
      tick();
      i_lsu_valid = 1'b0;
      tick();
      chk("rst1.pre_vld", 32'(o_ifu_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst1.ready", 32'(o_lsu_ready), 32'd1);
      chk("rst1.vld",   32'(o_ifu_valid), 32'd0);
      chk("rst1.wen",   32'(o_rf_gpr_wen), 32'd0);
      chk("rst1.rd_id", 32'(o_rf_rd_id), 32'd0);
      chk("rst1.rd",    o_rf_rd, 32'd0);
      chk("rst1.dnpc",  o_ifu_dnpc, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst1.quiet_wen", 32'(o_rf_gpr_wen), 32'd0);
         chk("rst1.quiet_vld", 32'(o_ifu_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
